// File: rtl/btn_value_editor_if.sv
// rtl/btn_value_editor_if.sv - switch/button inputs and edited-value outputs of btn_value_editor
interface btn_value_editor_if;
  logic [15:0] SW_I;
  logic        DBTN_C_I;
  logic        DBTN_U_I;
  logic        DBTN_L_I;
  logic        DBTN_R_I;
  logic        DBTN_D_I;
  logic [15:0] VALUE_O;
  logic [1:0]  DIGIT_SEL_O;
  logic        LOAD_O;
  logic [4:0]  EVT_O;

  modport slave (
    input  SW_I, DBTN_C_I, DBTN_U_I, DBTN_L_I, DBTN_R_I, DBTN_D_I,
    output VALUE_O, DIGIT_SEL_O, LOAD_O, EVT_O
  );

  modport master (
    output SW_I, DBTN_C_I, DBTN_U_I, DBTN_L_I, DBTN_R_I, DBTN_D_I,
    input  VALUE_O, DIGIT_SEL_O, LOAD_O, EVT_O
  );
endinterface

// File: rtl/btn_value_editor.sv
// rtl/btn_value_editor.sv - hex nibble editor driven by C/U/L/R/D buttons
// U/D auto-repeat is built only when BTN_VALUE_EDITOR_AUTO_REPEAT_EN is defined.
module btn_value_editor #(
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic              CLK100_I,
  input  logic              RST_I,
  btn_value_editor_if.slave bus
);
  // Button vectors use the EVT_O bit order {D,R,L,U,C}.
  logic [4:0]  btn_raw;
  logic [4:0]  s_q, p_q;
  logic [4:0]  press;
  logic [15:0] sw_q;
  logic [15:0] value_q, value_d;
  logic [1:0]  sel_q, sel_d;
  logic        load_q, load_d;
  logic [4:0]  evt_q, evt_d;
  logic [3:0]  nib;
  logic        rpt_fire;
  logic        rpt_dn;

  assign btn_raw = {bus.DBTN_D_I, bus.DBTN_R_I, bus.DBTN_L_I, bus.DBTN_U_I, bus.DBTN_C_I};
  assign press   = s_q & ~p_q;

  always_ff @(posedge CLK100_I) begin
    if (RST_I) begin
      s_q     <= '1;
      p_q     <= '1;
      sw_q    <= '0;
      value_q <= '0;
      sel_q   <= '0;
      load_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      s_q     <= btn_raw;
      p_q     <= s_q;
      sw_q    <= bus.SW_I;
      value_q <= value_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      evt_q   <= evt_d;
    end
  end

`ifdef BTN_VALUE_EDITOR_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_e;
  rpt_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        held_dn_q, held_dn_d;
  logic        held_s;

  always_ff @(posedge CLK100_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      held_dn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_dn_q <= held_dn_d;
    end
  end

  // Any accepted press edge preempts the repeat; a U/D press re-arms it for that button.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_dn_d = held_dn_q;
    rpt_fire  = 1'b0;
    held_s    = held_dn_q ? s_q[4] : s_q[1];
    if (|press) begin
      cnt_d = '0;
      if (press[0]) begin
        state_d = IDLE;
      end else if (press[1]) begin
        state_d   = HOLD;
        held_dn_d = 1'b0;
      end else if (press[4]) begin
        state_d   = HOLD;
        held_dn_d = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        HOLD, REPEAT: begin
          if (!held_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ((state_q == HOLD) ? 32'(REPEAT_DELAY - 1)
                                                    : 32'(REPEAT_RATE - 1))) begin
            rpt_fire = 1'b1;
            state_d  = REPEAT;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rpt_dn = held_dn_q;
`else
  assign rpt_fire = 1'b0;
  assign rpt_dn   = 1'b0;
`endif

  always_comb begin
    evt_d   = '0;
    value_d = value_q;
    sel_d   = sel_q;
    load_d  = 1'b0;
    nib     = value_q[{sel_q, 2'b00} +: 4];
    if (press[0])      evt_d = 5'b00001;
    else if (press[1]) evt_d = 5'b00010;
    else if (press[4]) evt_d = 5'b10000;
    else if (press[2]) evt_d = 5'b00100;
    else if (press[3]) evt_d = 5'b01000;
    else if (rpt_fire) evt_d = rpt_dn ? 5'b10000 : 5'b00010;

    if (evt_d[0]) begin
      value_d = sw_q;
      load_d  = 1'b1;
    end else if (evt_d[1]) begin
      value_d[{sel_q, 2'b00} +: 4] = nib + 4'd1;
    end else if (evt_d[4]) begin
      value_d[{sel_q, 2'b00} +: 4] = nib - 4'd1;
    end else if (evt_d[2]) begin
      sel_d = sel_q + 2'd1;
    end else if (evt_d[3]) begin
      sel_d = sel_q - 2'd1;
    end
  end

  assign bus.VALUE_O     = value_q;
  assign bus.DIGIT_SEL_O = sel_q;
  assign bus.LOAD_O      = load_q;
  assign bus.EVT_O       = evt_q;
endmodule

// File: doc/btn_value_editor.md
BTN_VALUE_EDITOR -- requirements
Module: btn_value_editor

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 50000000, giving the CLK100_I cycles a U/D button is held before the first auto-repeat (0.5 s).
REQ-002 SHALL have parameter REPEAT_RATE, default 10000000, giving the CLK100_I cycles between later auto-repeats (100 ms).
REQ-003 SHALL have port CLK100_I, input, 1 bit: 100 MHz board clock; the only clock.
REQ-004 SHALL have port RST_I, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port SW_I, input, 16 bits: switch value, loaded on a centre press.
REQ-006 SHALL have ports DBTN_C_I, DBTN_U_I, DBTN_L_I, DBTN_R_I and DBTN_D_I, input, 1 bit each: debounced button levels from the input controller.
REQ-007 SHALL have port VALUE_O, output, 16 bits: the edited value, as 4 hex nibbles.
REQ-008 SHALL have port DIGIT_SEL_O, output, 2 bits: the selected nibble index, 0 = bits 3:0.
REQ-009 SHALL have port LOAD_O, output, 1 bit: one-cycle pulse when VALUE_O is loaded from SW_I.
REQ-010 SHALL have port EVT_O, output, 5 bits: one-cycle pulse per accepted event, bit order {D,R,L,U,C}.

Function
REQ-011 SHALL register each DBTN input once (stage s) and again (stage p); a press edge = s & ~p.
REQ-012 SHALL update VALUE_O, DIGIT_SEL_O, LOAD_O and EVT_O on the 2nd clock edge after the first edge that samples the input high.
REQ-013 SHALL accept at most one event per cycle, priority C > U > D > L > R; lower-priority edges in the same cycle SHALL be discarded, not queued.
REQ-014 SHALL, on C, set VALUE_O to the SW_I value registered in the same cycle as the C edge, and pulse LOAD_O and EVT_O[0].
REQ-015 SHALL, on U, increment the selected nibble mod 16 (F->0) with no carry into other nibbles, and pulse EVT_O[1].
REQ-016 SHALL, on D, decrement the selected nibble mod 16 (0->F) with no borrow, and pulse EVT_O[4].
REQ-017 SHALL, on L, increment DIGIT_SEL_O mod 4 (3->0), and pulse EVT_O[2].
REQ-018 SHALL, on R, decrement DIGIT_SEL_O mod 4 (0->3), and pulse EVT_O[3].
REQ-019 SHALL assert EVT_O with at most one bit high, for exactly one cycle per event.
REQ-020 SHALL hold all outputs unchanged when no event is accepted.

Reset
REQ-021 SHALL, while RST_I is high at a clock edge, set VALUE_O=0x0000, DIGIT_SEL_O=0, LOAD_O=0, EVT_O=0, repeat FSM=IDLE and all counters to 0.
REQ-022 SHALL reset the s and p stages to 1, so a button held through reset release produces no event until it is released and pressed again.
REQ-023 SHALL, if reset is asserted mid-hold or mid-repeat, abort the repeat with no event in the reset cycle.

Configuration
REQ-024 SHALL compile the auto-repeat FSM and its counter only when macro BTN_VALUE_EDITOR_AUTO_REPEAT_EN is defined.
REQ-025 SHALL, with the macro defined, run FSM IDLE -> HOLD on an accepted U or D, recording the held button and clearing the counter.
REQ-026 SHALL, in HOLD, count while the held button's s stage is high; when the count reaches REPEAT_DELAY-1 it SHALL issue one repeat event for that button, enter REPEAT and clear the counter.
REQ-027 SHALL, in REPEAT, issue one repeat event each time the count reaches REPEAT_RATE-1, then clear the counter.
REQ-028 SHALL return to IDLE from HOLD or REPEAT when the held button's s stage goes low or any other press edge is accepted; that other event SHALL be processed normally in the same cycle.
REQ-029 SHALL process repeat events exactly like press events, including nibble wrap.
REQ-030 SHALL, without the macro, produce exactly one event per press however long the button is held; L, R and C never auto-repeat in either build.

Verification (bench uses REPEAT_DELAY=8, REPEAT_RATE=4)
REQ-031 SHALL cover: SW_I=0xA5C3, pulse C -> VALUE_O=0xA5C3 two edges later, LOAD_O and EVT_O=5'b00001 high for 1 cycle.
REQ-032 SHALL cover: VALUE_O=0x000F, DIGIT_SEL_O=0, press U -> VALUE_O=0x0000; then L x5 -> DIGIT_SEL_O=1; then D -> VALUE_O=0x00F0.
REQ-033 SHALL cover: C, U and R rising in the same cycle -> only the C event occurs, with EVT_O=5'b00001.
REQ-034 SHALL cover, with the macro: hold U for 20 cycles from VALUE_O=0 -> VALUE_O=0x0004 (one press event at +2, repeats at +10, +14, +18), and release -> no further events.
REQ-035 SHALL cover: U held high through RST_I pulse -> after reset, VALUE_O=0 and no event until U is released and re-pressed.
REQ-036 SHALL cover, without the macro: hold D for 100 cycles from VALUE_O=0 -> VALUE_O=0x000F, with exactly one EVT_O[4] pulse.
